// File: rtl/spa_pkg.sv
// Shared types for the SPA_FPGA edge driver: nibble width, field/phase enums, and a small max helper.
package spa_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [1:0] {FLD_SRC, FLD_DST, FLD_COST} field_e;

  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_STROBE, PH_GAP} phase_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spa_phase_timer.sv
// Loadable down-counter. Load takes effect at the next clock edge.
// expired_o is high while the count is 0, and the counter holds at 0.
module spa_phase_timer #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/spa_edge_driver.sv
// Replays (src,dst,cost) records as SETUP/STROBE/GAP nibble phases. Busy for 3*(S+T+G) cycles per record; edge_ready is low while busy.
// The SPA_EDGE_CHECK_EN macro adds a vertex range check at acceptance and an edge_err pulse output.
module spa_edge_driver #(
  parameter int DATA_W       = spa_pkg::DATA_W,
`ifdef SPA_EDGE_CHECK_EN
  parameter int NUM_VERTICES = 4,
`endif
  parameter int SETUP_CYC    = 2,
  parameter int STROBE_CYC   = 4,
  parameter int GAP_CYC      = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              edge_valid,
  output logic              edge_ready,
  input  logic [DATA_W-1:0] edge_src,
  input  logic [DATA_W-1:0] edge_dst,
  input  logic [DATA_W-1:0] edge_cost,
  input  logic              edge_last,
  output logic              in0,
  output logic              in1,
  output logic              in2,
  output logic              in3,
  output logic              run_source,
  output logic              run_dest,
  output logic              run_cost,
  output logic              busy,
  output logic              done,
  output logic [7:0]        edges_sent
`ifdef SPA_EDGE_CHECK_EN
  ,
  output logic              edge_err
`endif
);
  import spa_pkg::*;

  localparam int TW = $clog2(max3(SETUP_CYC, STROBE_CYC, GAP_CYC)) + 1;
  localparam logic [TW-1:0] SETUP_LD  = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] STROBE_LD = TW'(STROBE_CYC - 1);
  localparam logic [TW-1:0] GAP_LD    = TW'(GAP_CYC - 1);

  phase_e            phase_q, phase_d;
  field_e            field_q, field_d;
  logic [DATA_W-1:0] rec_src_q, rec_src_d;
  logic [DATA_W-1:0] rec_dst_q, rec_dst_d;
  logic [DATA_W-1:0] rec_cost_q, rec_cost_d;
  logic              rec_last_q, rec_last_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [7:0]        sent_q, sent_d;
  logic              tmr_load;
  logic [TW-1:0]     tmr_val;
  logic              tmr_expired;
  logic              accept;
  logic              rec_ok;
  logic [DATA_W-1:0] nib;

  assign accept = edge_valid & ready_q;

`ifdef SPA_EDGE_CHECK_EN
  localparam logic [DATA_W-1:0] NV = DATA_W'(NUM_VERTICES);
  assign rec_ok = (edge_src != edge_dst) && (edge_src != '0) && (edge_dst != '0) &&
                  (edge_src <= NV) && (edge_dst <= NV);
  assign edge_err = err_q;
`else
  assign rec_ok = 1'b1;
`endif

  spa_phase_timer #(.W(TW)) u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  always_comb begin
    phase_d    = phase_q;
    field_d    = field_q;
    rec_src_d  = rec_src_q;
    rec_dst_d  = rec_dst_q;
    rec_cost_d = rec_cost_q;
    rec_last_d = rec_last_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    sent_d     = sent_q;
    tmr_load   = 1'b0;
    tmr_val    = SETUP_LD;
    case (phase_q)
      PH_IDLE: begin
        if (accept) begin
          if (rec_ok) begin
            rec_src_d  = edge_src;
            rec_dst_d  = edge_dst;
            rec_cost_d = edge_cost;
            rec_last_d = edge_last;
            field_d    = FLD_SRC;
            phase_d    = PH_SETUP;
            tmr_load   = 1'b1;
          end else begin
            // Rejected record: stay ready, flag it, still honour end-of-graph.
            err_d  = 1'b1;
            done_d = edge_last;
          end
        end
      end
      PH_SETUP: begin
        if (tmr_expired) begin
          phase_d  = PH_STROBE;
          tmr_load = 1'b1;
          tmr_val  = STROBE_LD;
        end
      end
      PH_STROBE: begin
        if (tmr_expired) begin
          phase_d  = PH_GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
        end
      end
      PH_GAP: begin
        if (tmr_expired) begin
          if (field_q == FLD_COST) begin
            phase_d = PH_IDLE;
            sent_d  = sent_q + 8'd1;
            done_d  = rec_last_q;
          end else begin
            field_d  = (field_q == FLD_SRC) ? FLD_DST : FLD_COST;
            phase_d  = PH_SETUP;
            tmr_load = 1'b1;
          end
        end
      end
      default: phase_d = PH_IDLE;
    endcase
    ready_d = (phase_d == PH_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q    <= PH_IDLE;
      field_q    <= FLD_SRC;
      rec_src_q  <= '0;
      rec_dst_q  <= '0;
      rec_cost_q <= '0;
      rec_last_q <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      sent_q     <= '0;
    end else begin
      phase_q    <= phase_d;
      field_q    <= field_d;
      rec_src_q  <= rec_src_d;
      rec_dst_q  <= rec_dst_d;
      rec_cost_q <= rec_cost_d;
      rec_last_q <= rec_last_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      sent_q     <= sent_d;
    end
  end

  // Nibble is a pure function of registered state so reset clears it asynchronously.
  always_comb begin
    nib = '0;
    if (phase_q != PH_IDLE) begin
      case (field_q)
        FLD_SRC: nib = rec_src_q;
        FLD_DST: nib = rec_dst_q;
        default: nib = rec_cost_q;
      endcase
    end
  end

  assign in0        = nib[0];
  assign in1        = nib[1];
  assign in2        = nib[2];
  assign in3        = nib[3];
  assign run_source = (phase_q == PH_STROBE) && (field_q == FLD_SRC);
  assign run_dest   = (phase_q == PH_STROBE) && (field_q == FLD_DST);
  assign run_cost   = (phase_q == PH_STROBE) && (field_q == FLD_COST);
  assign busy       = (phase_q != PH_IDLE);
  assign edge_ready = ready_q;
  assign done       = done_q;
  assign edges_sent = sent_q;

endmodule

// File: tb/tb_spa_edge_driver.sv
// Scoreboard bench for spa_edge_driver: stimulus queues expected strobe/done/err events, a negedge monitor checks them.
module tb_spa_edge_driver;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       edge_valid = 1'b0;
  logic       edge_ready;
  logic [3:0] edge_src = '0, edge_dst = '0, edge_cost = '0;
  logic       edge_last = 1'b0;
  logic       in0, in1, in2, in3;
  logic       run_source, run_dest, run_cost, busy, done;
  logic [7:0] edges_sent;
`ifdef SPA_EDGE_CHECK_EN
  logic       edge_err;
`endif

  spa_edge_driver dut (
    .clock(clock), .reset_n(reset_n), .edge_valid(edge_valid), .edge_ready(edge_ready),
    .edge_src(edge_src), .edge_dst(edge_dst), .edge_cost(edge_cost), .edge_last(edge_last),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .run_source(run_source), .run_dest(run_dest), .run_cost(run_cost),
    .busy(busy), .done(done), .edges_sent(edges_sent)
`ifdef SPA_EDGE_CHECK_EN
    , .edge_err(edge_err)
`endif
  );

  always #5 clock = ~clock;

  // Event kinds: 0 src strobe, 1 dst strobe, 2 cost strobe, 3 done, 4 edge_err.
  typedef struct {int kind; logic [3:0] nib;} ev_t;
  ev_t exp_q[$];

  int n_chk = 0, n_pass = 0;
  int exp_edges = 0;
  int cyc = 0, acc_cnt = 0, acc_cyc = 0, done_cnt = 0, done_cyc = 0;
  int overlap_viol = 0, stable_viol = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic pop_cmp(input int kind, input logic [3:0] nib);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("sb_unexpected_event", kind, -1);
    end else begin
      e = exp_q.pop_front();
      chk("sb_kind", kind, e.kind);
      if (kind < 3) chk("sb_nibble", int'(nib), int'(e.nib));
    end
  endtask

  always @(posedge clock) begin
    cyc++;
    if (reset_n && edge_valid && edge_ready) begin
      acc_cnt++;
      acc_cyc = cyc;
    end
  end

  logic [2:0] prev_run = '0;
  logic       prev_busy = 1'b0;
  logic [3:0] prev_nib = '0;
  int since = 0, width = 0, blen = 0;

  always @(negedge clock) begin
    logic [2:0] run;
    logic [3:0] nib;
    int kind;
    run = {run_cost, run_dest, run_source};
    nib = {in3, in2, in1, in0};
    if (!reset_n) begin
      prev_run = '0; prev_busy = 1'b0; since = 0; width = 0; blen = 0;
    end else begin
      if ($countones(run) > 1) overlap_viol++;
      if (run != 0 && prev_run != 0 && nib != prev_nib) stable_viol++;
      if (busy && !prev_busy) since = 0;
      if (busy) blen++;
      if (!busy && prev_busy) begin
        chk("busy_len", blen, 24);
        blen = 0;
      end
      if (run != 0 && prev_run == 0) begin
        kind = (run == 3'b001) ? 0 : (run == 3'b010) ? 1 : 2;
        // SRC: 2 setup cycles after busy rises; later fields: 2 gap + 2 setup.
        chk("setup_len", since, (kind == 0) ? 2 : 4);
        width = 1;
        pop_cmp(kind, nib);
      end else if (run != 0) begin
        width++;
      end else begin
        if (prev_run != 0) begin
          chk("strobe_len", width, 4);
          since = 0;
        end
        if (busy) since++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("idle_nibble_at_done", int'(nib), 0);
        pop_cmp(3, nib);
      end
`ifdef SPA_EDGE_CHECK_EN
      if (edge_err) pop_cmp(4, nib);
`endif
      prev_run = run; prev_busy = busy; prev_nib = nib;
    end
  end

  task automatic send(input logic [3:0] s, input logic [3:0] d, input logic [3:0] c, input logic l);
    int t;
    bit bad;
    bad = 1'b0;
`ifdef SPA_EDGE_CHECK_EN
    bad = (s == d) || (s == 0) || (d == 0) || (s > 4) || (d > 4);
`endif
    if (bad) begin
      if (l) exp_q.push_back(ev_t'{3, 4'h0});
      exp_q.push_back(ev_t'{4, 4'h0});
    end else begin
      exp_q.push_back(ev_t'{0, s});
      exp_q.push_back(ev_t'{1, d});
      exp_q.push_back(ev_t'{2, c});
      if (l) exp_q.push_back(ev_t'{3, 4'h0});
      exp_edges++;
    end
    edge_src = s; edge_dst = d; edge_cost = c; edge_last = l; edge_valid = 1'b1;
    t = 0;
    while (!edge_ready && t < 300) begin
      @(negedge clock);
      t++;
    end
    if (!edge_ready) begin
      chk("send_timeout", 0, 1);
      return;
    end
    @(posedge clock);
    #1;
    chk("ready_after_accept", int'(edge_ready), int'(bad));
    chk("busy_after_accept", int'(busy), int'(!bad));
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (!(edge_ready && !busy) && t < 300);
    chk("wait_idle_in_budget", int'(edge_ready && !busy), 1);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t3_start, t;
    // 1: reset state and ready release
    #1;
    chk("rst_ready", int'(edge_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_edges", int'(edges_sent), 0);
    chk("rst_nibble", int'({in3, in2, in1, in0}), 0);
    chk("rst_runs", int'({run_cost, run_dest, run_source}), 0);
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    #1 chk("ready_before_clock", int'(edge_ready), 0);
    @(negedge clock);
    chk("ready_one_clock_after_release", int'(edge_ready), 1);

    // 2: single record 1/3/3
    send(4'd1, 4'd3, 4'd3, 1'b0);
    edge_valid = 1'b0;
    wait_idle();
    chk("t2_edges_sent", int'(edges_sent), exp_edges);

    // 3: three records with valid held, last on the third
    send(4'd3, 4'd4, 4'd1, 1'b0);
    t3_start = acc_cyc;
    send(4'd2, 4'd1, 4'd2, 1'b0);
    chk("t3_accept_stride", acc_cyc - t3_start, 25);
    send(4'd1, 4'd2, 4'd3, 1'b1);
    edge_valid = 1'b0;
    edge_last = 1'b0;
    wait_idle();
    // Records at +0/+25/+50 edges, 24 busy cycles each: done is high in cycle 75.
    chk("t3_done_cycle", done_cyc - t3_start + 1, 75);
    chk("t3_edges_sent", int'(edges_sent), exp_edges);

    // 4: reset during run_dest
    send(4'd2, 4'd3, 4'd4, 1'b0);
    edge_valid = 1'b0;
    t = 0;
    while (!run_dest && t < 100) begin
      @(negedge clock);
      t++;
    end
    chk("t4_reached_run_dest", int'(run_dest), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t4_run_dest_drop", int'(run_dest), 0);
    chk("t4_nibble_drop", int'({in3, in2, in1, in0}), 0);
    chk("t4_busy_drop", int'(busy), 0);
    chk("t4_edges_cleared", int'(edges_sent), 0);
    exp_q.delete();
    exp_edges = 0;
    @(negedge clock); @(negedge clock);
    #2 reset_n = 1'b1;
    send(4'd4, 4'd1, 4'd2, 1'b0);
    edge_valid = 1'b0;
    wait_idle();
    chk("t4_edges_after_restart", int'(edges_sent), exp_edges);

    // 5: bus changes while busy are ignored; the held bus is accepted in the next IDLE cycle
    send(4'd1, 4'd4, 4'd7, 1'b0);
    edge_src = 4'hE; edge_cost = 4'h0;
    repeat (5) @(negedge clock);
    send(4'd3, 4'd2, 4'd9, 1'b0);
    edge_valid = 1'b0;
    wait_idle();
    chk("t5_edges_sent", int'(edges_sent), exp_edges);

    // 6: src == dst (rejected only with the range check enabled)
    send(4'd2, 4'd2, 4'd5, 1'b0);
    edge_valid = 1'b0;
    wait_idle();
    chk("t6_edges_sent", int'(edges_sent), exp_edges);

    repeat (3) @(negedge clock);
    chk("sb_queue_drained", exp_q.size(), 0);
    chk("acceptance_count", acc_cnt, 9);
    chk("done_pulse_count", done_cnt, 1);
    chk("strobe_overlap", overlap_viol, 0);
    chk("nibble_stable_under_strobe", stable_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
